fantasticfft_fft8_unloader: RTL
===============================

Name: fantasticfft_fft8_unloader

Overview:
- Downstream neighbour of the 8-point FFT core; consumes its registered parallel result frame (8 real + 8 imaginary bins, plus resultValid).
- The FFT core has no backpressure and can emit a frame every cycle. This block absorbs frames into a 2-entry ping-pong frame buffer.
- It serialises each frame as one complex bin per beat on a valid/ready stream toward the consumer (magnitude stage, DMA, or host port).
- When both buffers are full, it drops new frames and flags the drop.

Parameters:
- INT_SIZE, 8, integer bits of the signed fixed-point sample; must match the FFT core.
- FRAC_SIZE, 8, fractional bits; sample width W = INT_SIZE+FRAC_SIZE.
- HALF_SPECTRUM, 0, 1 = emit bins 0..4 only (real-input conjugate symmetry); 0 = emit bins 0..7.
- DROP_CNT_W, 8, width of the saturating dropped-frame counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  one-cycle frame strobe (the FFT core's resultValid).
- in_re  in  8xW  packed real bins, bin k at [k*W +: W].
- in_im  in  8xW  packed imaginary bins, same packing.
- out_valid  out  1  a bin is presented.
- out_ready  in  1  consumer accepts when out_valid and out_ready are both high.
- out_re  out  W  real part of the current bin.
- out_im  out  W  imaginary part of the current bin.
- out_index  out  3  bin number of the current beat.
- out_last  out  1  high on the final bin of the frame (7, or 4 if HALF_SPECTRUM).
- overflow  out  1  sticky; set on any dropped frame.
- clr_overflow  in  1  one-cycle clear of overflow and drop_count.
- drop_count  out  DROP_CNT_W  saturating count of dropped frames.

Behaviour:
- Reset values: out_valid=0, out_index=0, out_last=0, overflow=0, drop_count=0, internal wr_ptr=0, rd_ptr=0, count=0. out_re and out_im are don't-care while out_valid=0.
- Storage: two frame slots, each 8 bins x (re,im). Write pointer wr_ptr, read pointer rd_ptr, occupancy count 0..2, bin counter idx 0..LAST.
- Capture: when in_valid and (count<2 or a final-beat handshake occurs this cycle), write in_re and in_im into slot wr_ptr, then toggle wr_ptr.
- Drop: when in_valid, count==2 and no final-beat handshake this cycle, discard the frame. Set overflow. Increment drop_count, saturating at all-ones.
- count update: +1 on capture, -1 on final-beat handshake, unchanged if both or neither occur.
- Latency: a frame captured at edge N gives out_valid=1 with idx 0 from edge N+1. One beat per cycle under continuous ready, so a full frame takes 8 cycles, or 5 with HALF_SPECTRUM.
- out_valid = (count!=0). out_re and out_im = slot[rd_ptr][idx]. out_index = idx. out_last = (idx==LAST).
- Outputs are driven combinationally from registered state only; no input-to-output path.
- While out_valid and !out_ready, all out_* hold stable.
- Handshake on a non-final beat: idx increments. Handshake on the final beat: idx returns to 0, rd_ptr toggles, count decrements.
- Back-to-back frames: the next frame's bin 0 follows the previous frame's last bin with no bubble if count stays >=1.
- Capture writes only slot wr_ptr, which is never the slot being read when count>=1, so simultaneous capture and read are safe.
- clr_overflow together with a drop in the same cycle: the drop wins; overflow=1 and drop_count=1.
- Reset mid-frame: buffered frames are abandoned and out_valid falls in the cycle after reset is sampled. An in_valid coincident with rst is ignored.
- Arithmetic: none on sample data; bins pass through bit-exact.

Decomposition:
- Shared package fantasticfft_pkg holds the fixed-point width localparam W and a sample typedef (signed [W-1:0]). It also holds the fft8 bin-count constant (8) and LAST_FULL=7 / LAST_HALF=4.
- One natural sub-module: fantasticfft_frame_buf, a 2-slot x 8-bin register file with a write port and a (slot, bin) read port. The pointer, count and idx control stays in the parent.

Test Plan:
- Single frame, in_re bin k = 16'h0100*k, in_im = -bin k; out_ready=1 -> out_valid rises 1 cycle after in_valid. 8 beats follow with out_index 0..7 and matching data, out_last only on index 7, then out_valid=0.
- Stall: out_ready toggled 1,0,0,1 during a frame -> out_re, out_im and out_index hold across stall cycles; no bin skipped or repeated.
- Overflow: out_ready=0, three frames on consecutive cycles -> frames 1 and 2 are buffered, frame 3 dropped; overflow=1, drop_count=1. With ready raised, frames 1 then 2 are emitted intact.
- Simultaneous free and capture: count=2 and a third in_valid on the cycle of the final-beat handshake -> frame accepted, no drop; 24 contiguous beats total.
- HALF_SPECTRUM=1: one frame -> exactly 5 beats, out_index 0..4, out_last on 4.
- Reset mid-frame at beat 3 -> out_valid=0 the next cycle; a later frame streams from index 0 with correct data. clr_overflow then returns overflow=0 and drop_count=0.

Source files
------------

// File: rtl/fantasticfft_pkg.sv
// Shared constants and types for the fantasticfft datapath.
// Holds the default fixed-point geometry, the fft8 bin count and the
// last-bin numbers for full- and half-spectrum serialisation.
package fantasticfft_pkg;

  localparam int unsigned DEF_INT_SIZE  = 8;
  localparam int unsigned DEF_FRAC_SIZE = 8;
  localparam int unsigned W             = DEF_INT_SIZE + DEF_FRAC_SIZE;

  localparam int unsigned NUM_BINS  = 8;
  localparam int unsigned BIN_W     = 3;
  localparam int unsigned NUM_SLOTS = 2;
  localparam int unsigned LAST_FULL = 7;
  localparam int unsigned LAST_HALF = 4;

  typedef logic signed [W-1:0] sample_t;

  // Final bin index of a serialised frame; half spectrum stops at Nyquist.
  function automatic logic [BIN_W-1:0] last_bin(input logic half);
    return half ? BIN_W'(LAST_HALF) : BIN_W'(LAST_FULL);
  endfunction

endpackage

// File: rtl/fantasticfft_frame_buf.sv
// Two-slot frame register file for the fft8 unloader.
// Ports:
//   clk      - rising-edge clock
//   wr_en    - write a whole frame into slot wr_slot
//   wr_slot  - target slot of the write
//   wr_re/im - packed frame, bin k at [k*SW +: SW]
//   rd_slot  - slot being read
//   rd_bin   - bin within the read slot
//   rd_re/im - selected bin, combinational from storage
// Storage carries no reset: a slot is only read after it has been written.
module fantasticfft_frame_buf
  import fantasticfft_pkg::*;
#(
  parameter int unsigned SW = W
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic                   wr_slot,
  input  logic [NUM_BINS*SW-1:0] wr_re,
  input  logic [NUM_BINS*SW-1:0] wr_im,
  input  logic                   rd_slot,
  input  logic [BIN_W-1:0]       rd_bin,
  output logic [SW-1:0]          rd_re,
  output logic [SW-1:0]          rd_im
);

  logic [NUM_BINS*SW-1:0] re_q [NUM_SLOTS];
  logic [NUM_BINS*SW-1:0] im_q [NUM_SLOTS];

  // Whole-frame write; the FFT core presents all bins in one cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      re_q[wr_slot] <= wr_re;
      im_q[wr_slot] <= wr_im;
    end
  end

  // Bin select for the serialiser.
  always_comb begin
    rd_re = re_q[rd_slot][32'(rd_bin)*SW +: SW];
    rd_im = im_q[rd_slot][32'(rd_bin)*SW +: SW];
  end

endmodule

// File: rtl/fantasticfft_fft8_unloader.sv
// Serialiser for the fft8 core's parallel result frame.
// Captures whole frames into a two-slot ping-pong buffer and streams them
// out one complex bin per beat on a valid/ready interface. Frames arriving
// while both slots are occupied (and none frees this cycle) are dropped and
// counted.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_valid          - one-cycle frame strobe from the FFT core
//   in_re, in_im      - packed bins, bin k at [k*W +: W]
//   out_valid/ready   - output stream handshake
//   out_re, out_im    - current bin value
//   out_index         - current bin number
//   out_last          - final bin of the frame
//   overflow          - sticky drop flag
//   clr_overflow      - clears overflow and drop_count
//   drop_count        - saturating dropped-frame count
module fantasticfft_fft8_unloader
  import fantasticfft_pkg::*;
#(
  parameter int unsigned INT_SIZE      = DEF_INT_SIZE,
  parameter int unsigned FRAC_SIZE     = DEF_FRAC_SIZE,
  parameter int unsigned HALF_SPECTRUM = 0,
  parameter int unsigned DROP_CNT_W    = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  input  logic [NUM_BINS*(INT_SIZE+FRAC_SIZE)-1:0] in_re,
  input  logic [NUM_BINS*(INT_SIZE+FRAC_SIZE)-1:0] in_im,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [INT_SIZE+FRAC_SIZE-1:0]            out_re,
  output logic [INT_SIZE+FRAC_SIZE-1:0]            out_im,
  output logic [BIN_W-1:0]                         out_index,
  output logic                                     out_last,
  output logic                                     overflow,
  input  logic                                     clr_overflow,
  output logic [DROP_CNT_W-1:0]                    drop_count
);

  localparam int unsigned SW = INT_SIZE + FRAC_SIZE;
  localparam logic [BIN_W-1:0] LAST = last_bin(HALF_SPECTRUM != 0);

  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [BIN_W-1:0]  idx;

  logic                  hs_c;
  logic                  fin_c;
  logic                  capture_c;
  logic                  drop_c;
  logic                  wr_en_c;
  logic [DROP_CNT_W-1:0] dc_base_c;
  logic [DROP_CNT_W-1:0] dc_next_c;

  // Handshake, capture and drop decisions for this cycle.
  // A final-beat handshake frees a slot in time for a same-cycle capture.
  always_comb begin
    hs_c      = out_valid & out_ready;
    fin_c     = hs_c & (idx == LAST);
    capture_c = in_valid & ((count != 2'd2) | fin_c);
    drop_c    = in_valid & ~capture_c;
    wr_en_c   = capture_c & ~rst;
    // A clear coinciding with a drop restarts the count at one.
    dc_base_c = clr_overflow ? '0 : drop_count;
    dc_next_c = (&dc_base_c) ? dc_base_c : dc_base_c + DROP_CNT_W'(1);
  end

  // Pointer, occupancy, bin counter and drop bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      idx        <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (capture_c) begin
        wr_ptr <= ~wr_ptr;
      end

      if (hs_c) begin
        if (fin_c) begin
          idx    <= '0;
          rd_ptr <= ~rd_ptr;
        end else begin
          idx <= idx + BIN_W'(1);
        end
      end

      case ({capture_c, fin_c})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      if (drop_c) begin
        overflow   <= 1'b1;
        drop_count <= dc_next_c;
      end else if (clr_overflow) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end

  // Capture only ever targets the slot not under read while count>=1.
  fantasticfft_frame_buf #(
    .SW (SW)
  ) u_frame_buf (
    .clk     (clk),
    .wr_en   (wr_en_c),
    .wr_slot (wr_ptr),
    .wr_re   (in_re),
    .wr_im   (in_im),
    .rd_slot (rd_ptr),
    .rd_bin  (idx),
    .rd_re   (out_re),
    .rd_im   (out_im)
  );

  // Stream status is a pure function of registered state.
  always_comb begin
    out_valid = (count != 2'd0);
    out_index = idx;
    out_last  = (idx == LAST);
  end

endmodule
